// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared state type and index helper for the round-robin index arbiter
package rr_arb_pkg;

   typedef enum logic {IDLE, OFFER} arb_state_t;

   // Advance an index by one, wrapping back to 0 past the last requester.
   function automatic int wrap_inc(input int idx, input int req);
      return (idx + 1 >= req) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/pri_enc.sv
// rtl/pri_enc.sv - find-first-set (lowest index wins) to binary, with a hit flag
module pri_enc #(
   parameter int N = 8,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] vec,
   output logic [W-1:0] idx,
   output logic         hit
);

   // Scan from the top down, so the lowest set bit is the last to write idx.
   always_comb begin
      idx = '0;
      hit = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = W'(i);
            hit = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_idx_arb.sv
// rtl/rr_idx_arb.sv - round-robin arbiter with a registered binary grant index and valid/ready offer
module rr_idx_arb
   import rr_arb_pkg::*;
#(
   parameter int   REQ = 8,
   parameter int   IDX = $clog2(REQ),
   parameter logic ACT = 1'b1
) (
   input  logic           clk,
   input  logic           reset_,
   input  logic [REQ-1:0] req,
   input  logic           lock,
   input  logic           ready,
   output logic           valid,
   output logic [IDX-1:0] grant_idx
);

   localparam logic [IDX:0] REQ_W = (IDX + 1)'(REQ);

   arb_state_t     state_q, state_d;
   logic [IDX-1:0] grant_q, grant_d;
   logic [IDX-1:0] ptr_q, ptr_d;
   logic [IDX-1:0] next_ptr, search_ptr, enc_idx, winner;
   logic [REQ-1:0] act_req, rot;
   logic [IDX:0]   rot_src, win_sum;
   logic           accept, hit;

   assign valid     = (state_q == OFFER);
   assign grant_idx = grant_q;
   assign accept    = valid && ready;

   // The reload on an accept edge must already see the post-accept pointer.
   assign next_ptr   = lock ? grant_q : IDX'(wrap_inc(int'(grant_q), REQ));
   assign search_ptr = accept ? next_ptr : ptr_q;

   always_comb begin
      act_req = '0;
      rot     = '0;
      rot_src = '0;
      for (int i = 0; i < REQ; i++) begin
         act_req[i] = (req[i] == ACT);
      end
      // Rotate right by search_ptr so position 0 is the highest-priority candidate.
      for (int i = 0; i < REQ; i++) begin
         rot_src = {1'b0, IDX'(i)} + {1'b0, search_ptr};
         if (rot_src >= REQ_W) rot_src = rot_src - REQ_W;
         rot[i] = act_req[rot_src[IDX-1:0]];
      end
   end

   pri_enc #(.N(REQ), .W(IDX)) u_pri_enc (
      .vec (rot),
      .idx (enc_idx),
      .hit (hit)
   );

   always_comb begin
      win_sum = {1'b0, enc_idx} + {1'b0, search_ptr};
      if (win_sum >= REQ_W) win_sum = win_sum - REQ_W;
      winner = win_sum[IDX-1:0];
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      if (accept) ptr_d = next_ptr;
      if (state_q == IDLE || accept) begin
         if (hit) begin
            state_d = OFFER;
            grant_d = winner;
         end else begin
            state_d = IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state_q <= IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
      end
   end

endmodule

// File: tb/tb_rr_idx_arb.sv
// tb/tb_rr_idx_arb.sv - self-checking bench for rr_idx_arb at REQ=8 and REQ=5
module tb_rr_idx_arb;

   logic       clk = 1'b0;
   logic       reset_ = 1'b0;
   logic       lock = 1'b0;
   logic       ready = 1'b0;
   logic [7:0] req8 = 8'h00;
   logic [4:0] req5 = 5'h00;
   logic       valid8, valid5;
   logic [2:0] grant8, grant5;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rr_idx_arb #(.REQ(8), .ACT(1'b1)) dut8 (
      .clk(clk), .reset_(reset_), .req(req8), .lock(lock), .ready(ready),
      .valid(valid8), .grant_idx(grant8)
   );

   rr_idx_arb #(.REQ(5), .ACT(1'b1)) dut5 (
      .clk(clk), .reset_(reset_), .req(req5), .lock(lock), .ready(ready),
      .valid(valid5), .grant_idx(grant5)
   );

   // Behavioural model: index 0 is the REQ=8 instance, index 1 the REQ=5 instance.
   int m_valid[2];
   int m_grant[2];
   int m_ptr[2];
   int m_n[2] = '{8, 5};

   function automatic int req_bit(int u, int i);
      return (u == 0) ? int'(req8[i]) : int'(req5[i]);
   endfunction

   always @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         for (int u = 0; u < 2; u++) begin
            m_valid[u] = 0; m_grant[u] = 0; m_ptr[u] = 0;
         end
      end else begin
         for (int u = 0; u < 2; u++) begin
            int p;
            int found;
            p = m_ptr[u];
            if (m_valid[u] != 0 && ready) p = lock ? m_grant[u] : (m_grant[u] + 1) % m_n[u];
            if (m_valid[u] == 0 || ready) begin
               found = -1;
               for (int k = 0; k < m_n[u]; k++) begin
                  if (found < 0 && req_bit(u, (p + k) % m_n[u]) == 1) found = (p + k) % m_n[u];
               end
               if (found >= 0) begin
                  m_valid[u] = 1; m_grant[u] = found;
               end else begin
                  m_valid[u] = 0;
               end
            end
            m_ptr[u] = p;
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Continuous comparison against the model, away from the active edge.
   always @(negedge clk) begin
      logic [7:0] dec;
      check("model_valid8", int'(valid8), m_valid[0]);
      check("model_grant8", int'(grant8), m_grant[0]);
      check("model_valid5", int'(valid5), m_valid[1]);
      check("model_grant5", int'(grant5), m_grant[1]);
      check("grant5_range", int'(grant5 <= 3'd4), 1);
      dec = 8'd1 << grant5;
      check("bin_dec5_onehot", int'(dec == 8'd1 || dec == 8'd16), 1);
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset(input logic [7:0] r8, input logic [4:0] r5);
      ready  = 1'b0;
      lock   = 1'b0;
      reset_ = 1'b0;
      req8   = r8;
      req5   = r5;
      cyc();
      reset_ = 1'b1;
   endtask

   initial begin
      // Reset with all requests active
      req8 = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("reset_valid", int'(valid8), 0);
         check("reset_grant", int'(grant8), 0);
      end
      reset_ = 1'b1;
      cyc();
      check("post_reset_valid", int'(valid8), 1);
      check("post_reset_grant", int'(grant8), 0);

      // Round-robin over all requesters
      ready = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         cyc();
         check("rr_grant", int'(grant8), k % 8);
         check("rr_valid", int'(valid8), 1);
      end

      // Stall with sticky offer, req[2] dropped during the stall
      do_reset(8'h24, 5'h00);
      cyc();
      check("stall_first", int'(grant8), 2);
      for (int i = 0; i < 5; i++) begin
         if (i == 1) req8 = 8'h20;
         cyc();
         check("stall_hold", int'(grant8), 2);
         check("stall_valid", int'(valid8), 1);
      end
      ready = 1'b1;
      cyc();
      check("stall_release", int'(grant8), 5);
      ready = 1'b0;

      // Lock burst
      do_reset(8'h09, 5'h00);
      cyc();
      check("lock_0", int'(grant8), 0);
      ready = 1'b1;
      lock  = 1'b1;
      cyc();
      check("lock_1", int'(grant8), 0);
      cyc();
      check("lock_2", int'(grant8), 0);
      lock = 1'b0;
      cyc();
      check("lock_3", int'(grant8), 3);
      cyc();
      check("lock_4", int'(grant8), 0);

      // Non-power-of-two wrap on the REQ=5 instance
      do_reset(8'h00, 5'b10001);
      cyc();
      check("npot_0", int'(grant5), 0);
      ready = 1'b1;
      cyc();
      check("npot_1", int'(grant5), 4);
      cyc();
      check("npot_2", int'(grant5), 0);
      cyc();
      check("npot_3", int'(grant5), 4);
      check("npot_valid", int'(valid5), 1);
      check("npot_idle8", int'(valid8), 0);

      // Mid-offer reset while offering index 6
      do_reset(8'hFF, 5'h00);
      cyc();
      ready = 1'b1;
      for (int i = 0; i < 6; i++) cyc();
      ready = 1'b0;
      check("mid_pre_grant", int'(grant8), 6);
      #3;
      reset_ = 1'b0;
      #1;
      check("mid_async_valid", int'(valid8), 0);
      check("mid_async_grant", int'(grant8), 0);
      #2;
      reset_ = 1'b1;
      cyc();
      check("mid_after_grant", int'(grant8), 0);
      check("mid_after_valid", int'(valid8), 1);

      cyc();
      cyc();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
